// File: rtl/game_pkg.sv
// Shared game definitions: coordinate type, game-state code, item selector,
// and the reset / fallback cells for the two board items.
package game_pkg;

  localparam int unsigned COORD_W = 4;
  localparam int unsigned STATE_W = 3;

  typedef logic [COORD_W-1:0] coord_t;

  // One board cell; x in the upper nibble, y in the lower nibble.
  typedef struct packed {
    coord_t x;
    coord_t y;
  } cell_t;

  typedef enum logic {
    ITEM_FOOD   = 1'b0,
    ITEM_POISON = 1'b1
  } item_e;

  localparam logic [STATE_W-1:0] ST_PLAY = 3'b010;

  localparam cell_t FOOD_RST_CELL   = '{x: 4'd10, y: 4'd7};
  localparam cell_t POISON_RST_CELL = '{x: 4'd5,  y: 4'd3};
  localparam cell_t FOOD_FB_CELL    = '{x: 4'd2,  y: 4'd2};
  localparam cell_t POISON_FB_CELL  = '{x: 4'd13, y: 4'd13};

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Galois LFSR (mask 8'hB8), right-shifting.
// Ports: clk, reset (async, active-low), o_lfsr (current register value).
// A non-zero seed keeps the register out of the all-zero lock-up state.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] o_lfsr
);

  localparam logic [7:0] MASK = 8'hB8;

  logic [7:0] r_lfsr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_lfsr <= SEED;
    else        r_lfsr <= {1'b0, r_lfsr[7:1]} ^ (r_lfsr[0] ? MASK : 8'h00);
  end

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/item_spawn_ctrl.sv
// Respawn sequencer for the food and poison items on the 16x16 board.
// Touches queue a respawn; one shared LFSR proposes cells, rejecting those
// that hit the head, the other item or the item's own cell; after
// MAX_TRIES rejections the item's fallback cell is used.
// Ports: clk, reset (async active-low), state, tick, TouchFood, TouchPoison,
//        head_x/head_y in; food_x/food_y, poison_x/poison_y, busy,
//        spawn_done out (all registered).
// Optional feature: define POISON_TIMEOUT_EN to force a poison respawn after
// 40 play ticks without one.
module item_spawn_ctrl
  import game_pkg::*;
#(
  parameter logic [STATE_W-1:0] PLAY_STATE    = ST_PLAY,
  parameter int unsigned        RESPAWN_DELAY = 2,
  parameter int unsigned        MAX_TRIES     = 8,
  parameter logic [7:0]         LFSR_SEED     = 8'hA5
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   state,
  input  logic         tick,
  input  logic         TouchFood,
  input  logic         TouchPoison,
  input  logic [3:0]   head_x,
  input  logic [3:0]   head_y,
  output logic [3:0]   food_x,
  output logic [3:0]   food_y,
  output logic [3:0]   poison_x,
  output logic [3:0]   poison_y,
  output logic         busy,
  output logic         spawn_done
);

  localparam int unsigned WAIT_W = (RESPAWN_DELAY > 1) ? $clog2(RESPAWN_DELAY) : 1;
  localparam int unsigned TRY_W  = 4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GEN, S_CHECK} fsm_e;

  fsm_e              r_fsm, w_fsm_nxt;
  item_e             r_sel, w_sel_nxt;
  logic [TRY_W-1:0]  r_tries, w_tries_nxt;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_nxt;
  cell_t             r_cand, w_cand_nxt;
  cell_t             r_food, w_food_nxt;
  cell_t             r_poison, w_poison_nxt;
  logic              r_pend_food, w_pend_food_nxt;
  logic              r_pend_poison, w_pend_poison_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_spawn_done, w_done_nxt;

  logic              w_in_play, w_clr_food, w_clr_poison, w_commit_poison;
  logic              w_food_svc, w_poison_svc, w_reject;
  logic              w_poison_req;
  cell_t             w_head, w_own, w_other;
  logic [7:0]        w_lfsr;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .o_lfsr (w_lfsr)
  );

  assign w_in_play = (state == PLAY_STATE);
  assign w_head    = {head_x, head_y};

  // Poison inactivity timer: acts as an internal poison touch.
`ifdef POISON_TIMEOUT_EN
  localparam int unsigned TO_W     = 6;
  localparam int unsigned TO_TICKS = 40;
  logic [TO_W-1:0] r_to_cnt;
  logic            w_to_hit;

  assign w_to_hit = w_in_play & tick & (r_to_cnt == TO_W'(TO_TICKS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          r_to_cnt <= '0;
    else if (w_commit_poison || w_to_hit) r_to_cnt <= '0;
    else if (w_in_play && tick)          r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`else
  logic w_to_hit;
  assign w_to_hit = 1'b0;
`endif

  assign w_poison_req = TouchPoison | w_to_hit;

  // Sequencer next-state, candidate check and position updates.
  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_sel_nxt       = r_sel;
    w_tries_nxt     = r_tries;
    w_wait_nxt      = r_wait_cnt;
    w_cand_nxt      = r_cand;
    w_food_nxt      = r_food;
    w_poison_nxt    = r_poison;
    w_done_nxt      = 1'b0;
    w_clr_food      = 1'b0;
    w_clr_poison    = 1'b0;
    w_commit_poison = 1'b0;
    w_own           = (r_sel == ITEM_FOOD) ? r_food : r_poison;
    w_other         = (r_sel == ITEM_FOOD) ? r_poison : r_food;
    w_reject        = (r_cand == w_head) || (r_cand == w_other) || (r_cand == w_own);

    if (!w_in_play) begin
      w_fsm_nxt = S_IDLE;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          w_tries_nxt = '0;
          w_wait_nxt  = '0;
          if (r_pend_food || r_pend_poison) begin
            w_sel_nxt    = r_pend_food ? ITEM_FOOD : ITEM_POISON;
            w_clr_food   = r_pend_food;
            w_clr_poison = !r_pend_food;
            w_fsm_nxt    = (RESPAWN_DELAY == 0) ? S_GEN : S_WAIT;
          end
        end
        S_WAIT: begin
          if (tick) begin
            if (32'(r_wait_cnt) + 32'd1 >= RESPAWN_DELAY) w_fsm_nxt = S_GEN;
            else w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          end
        end
        S_GEN: begin
          w_cand_nxt = cell_t'(w_lfsr);
          w_fsm_nxt  = S_CHECK;
        end
        S_CHECK: begin
          if (w_reject && (32'(r_tries) + 32'd1 < MAX_TRIES)) begin
            w_tries_nxt = r_tries + TRY_W'(1);
            w_fsm_nxt   = S_GEN;
          end else begin
            if (r_sel == ITEM_FOOD) begin
              w_food_nxt = w_reject ? FOOD_FB_CELL : r_cand;
            end else begin
              w_poison_nxt    = w_reject ? POISON_FB_CELL : r_cand;
              w_commit_poison = 1'b1;
            end
            w_done_nxt = 1'b1;
            w_fsm_nxt  = S_IDLE;
          end
        end
        default: w_fsm_nxt = S_IDLE;
      endcase
    end

    // A touch for an item already pending or being placed is dropped.
    w_food_svc        = (r_fsm != S_IDLE) && (r_sel == ITEM_FOOD);
    w_poison_svc      = (r_fsm != S_IDLE) && (r_sel == ITEM_POISON);
    w_pend_food_nxt   = w_in_play & ((r_pend_food & ~w_clr_food) |
                                     (TouchFood & ~r_pend_food & ~w_food_svc));
    w_pend_poison_nxt = w_in_play & ((r_pend_poison & ~w_clr_poison) |
                                     (w_poison_req & ~r_pend_poison & ~w_poison_svc));
    w_busy_nxt        = w_pend_food_nxt | w_pend_poison_nxt | (w_fsm_nxt != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fsm         <= S_IDLE;
      r_sel         <= ITEM_FOOD;
      r_tries       <= '0;
      r_wait_cnt    <= '0;
      r_cand        <= '0;
      r_food        <= FOOD_RST_CELL;
      r_poison      <= POISON_RST_CELL;
      r_pend_food   <= 1'b0;
      r_pend_poison <= 1'b0;
      r_busy        <= 1'b0;
      r_spawn_done  <= 1'b0;
    end else begin
      r_fsm         <= w_fsm_nxt;
      r_sel         <= w_sel_nxt;
      r_tries       <= w_tries_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_cand        <= w_cand_nxt;
      r_food        <= w_food_nxt;
      r_poison      <= w_poison_nxt;
      r_pend_food   <= w_pend_food_nxt;
      r_pend_poison <= w_pend_poison_nxt;
      r_busy        <= w_busy_nxt;
      r_spawn_done  <= w_done_nxt;
    end
  end

  assign food_x     = r_food.x;
  assign food_y     = r_food.y;
  assign poison_x   = r_poison.x;
  assign poison_y   = r_poison.y;
  assign busy       = r_busy;
  assign spawn_done = r_spawn_done;

endmodule

// File: tb/tb_item_spawn_ctrl.sv
// Directed bench for item_spawn_ctrl: one instance with no respawn delay,
// one with the default two-tick delay, both on shared stimulus.
module tb_item_spawn_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] state;
  logic       tick, touch_food, touch_poison;
  logic [3:0] hx, hy, head_x, head_y;
  logic       track;

  logic [3:0] f0x, f0y, p0x, p0y, f2x, f2y, p2x, p2y;
  logic       busy0, done0, busy2, done2;

  int checks   = 0;
  int failures = 0;

  logic [7:0] m_lfsr, m_prev;

  always #5 clk = ~clk;

  item_spawn_ctrl #(.RESPAWN_DELAY(0)) u_dut0 (
    .clk(clk), .reset(rst_n), .state(state), .tick(tick),
    .TouchFood(touch_food), .TouchPoison(touch_poison),
    .head_x(head_x), .head_y(head_y),
    .food_x(f0x), .food_y(f0y), .poison_x(p0x), .poison_y(p0y),
    .busy(busy0), .spawn_done(done0)
  );

  item_spawn_ctrl u_dut2 (
    .clk(clk), .reset(rst_n), .state(state), .tick(tick),
    .TouchFood(touch_food), .TouchPoison(touch_poison),
    .head_x(head_x), .head_y(head_y),
    .food_x(f2x), .food_y(f2y), .poison_x(p2x), .poison_y(p2y),
    .busy(busy2), .spawn_done(done2)
  );

  function automatic logic [7:0] nxt(input logic [7:0] l);
    return {1'b0, l[7:1]} ^ (l[0] ? 8'hB8 : 8'h00);
  endfunction

  // Reference generator; m_prev is the value a GEN edge would have latched.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_prev <= 8'hA5;
    end else begin
      m_prev <= m_lfsr;
      m_lfsr <= nxt(m_lfsr);
    end
  end

  assign head_x = track ? m_prev[7:4] : hx;
  assign head_y = track ? m_prev[3:0] : hy;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [7:0] exp_cell, f_old, p_old;
    int         cnt, nd;
    bit         got;

    rst_n = 1'b0; state = 3'b010; tick = 1'b0;
    touch_food = 1'b0; touch_poison = 1'b0;
    hx = 4'd0; hy = 4'd0; track = 1'b0;

    // 1: reset values, then quiet for 20 cycles
    step(3);
    check("rst_food0",   {f0x, f0y}, 8'hA7);
    check("rst_poison0", {p0x, p0y}, 8'h53);
    check("rst_busy0",   busy0, 0);
    check("rst_done0",   done0, 0);
    check("rst_food2",   {f2x, f2y}, 8'hA7);
    check("rst_busy2",   busy2, 0);
    rst_n = 1'b1;
    nd = 0;
    repeat (20) begin
      step(1);
      if (done0 || done2 || busy0 || busy2) nd++;
    end
    check("idle_no_activity", nd, 0);
    check("idle_poison0", {p0x, p0y}, 8'h53);

    // 2: poison respawn latency with first candidate accepted
    for (int k = 0; k < 16; k++) begin
      exp_cell = nxt(nxt(m_lfsr));
      if (exp_cell != 8'h00 && exp_cell != 8'hA7 && exp_cell != 8'h53) break;
      step(1);
    end
    exp_cell = nxt(nxt(m_lfsr));
    touch_poison = 1'b1;
    step(1);
    touch_poison = 1'b0;
    check("t2_busy_after_sample", busy0, 1);
    step(2);
    check("t2_poison_hold_n2", {p0x, p0y}, 8'h53);
    check("t2_done_n2", done0, 0);
    step(1);
    check("t2_poison_n3", {p0x, p0y}, exp_cell);
    check("t2_done_n3", done0, 1);
    check("t2_busy_n3", busy0, 0);
    check("t2_food_hold", {f0x, f0y}, 8'hA7);
    step(1);
    check("t2_done_single", done0, 0);

    // 3: simultaneous touches, food served first
    f_old = {f0x, f0y};
    p_old = {p0x, p0y};
    touch_food = 1'b1; touch_poison = 1'b1;
    step(1);
    touch_food = 1'b0; touch_poison = 1'b0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step(1);
      if (done0) got = 1;
    end
    check("t3_first_done", got, 1);
    check("t3_food_moved", ({f0x, f0y} != f_old), 1);
    check("t3_poison_waits", {p0x, p0y}, p_old);
    check("t3_busy_between", busy0, 1);
    f_old = {f0x, f0y};
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step(1);
      if (done0) got = 1;
    end
    check("t3_second_done", got, 1);
    check("t3_poison_moved", ({p0x, p0y} != p_old), 1);
    check("t3_food_held", {f0x, f0y}, f_old);
    check("t3_busy_falls", busy0, 0);

    // 4: head shadows every candidate -> fallback after 8 rejections
    f_old = {f0x, f0y};
    track = 1'b1;
    touch_poison = 1'b1;
    step(1);
    touch_poison = 1'b0;
    cnt = 0;
    got = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      step(1);
      cnt++;
      if (done0) got = 1;
    end
    check("t4_done", got, 1);
    check("t4_latency", cnt, 17);
    check("t4_fallback", {p0x, p0y}, 8'hDD);
    check("t4_food_held", {f0x, f0y}, f_old);
    track = 1'b0;

    // 5a: touches outside play are ignored
    state = 3'b001;
    touch_food = 1'b1;
    step(3);
    touch_food = 1'b0;
    check("t5_food0_held", {f0x, f0y}, f_old);
    check("t5_busy0", busy0, 0);
    check("t5_busy2", busy2, 0);
    check("t5_food2_rst", {f2x, f2y}, 8'hA7);

    // 5b: leaving play during WAIT aborts without commit
    state = 3'b010;
    touch_food = 1'b1;
    step(1);
    touch_food = 1'b0;
    step(2);
    check("t5_wait_busy2", busy2, 1);
    tick = 1'b1; step(1); tick = 1'b0;
    state = 3'b001;
    step(1);
    check("t5_abort_busy2", busy2, 0);
    check("t5_abort_done2", done2, 0);
    check("t5_abort_food2", {f2x, f2y}, 8'hA7);
    state = 3'b010;
    step(2);

    // 5c: delayed placement waits for two ticks
    touch_food = 1'b1;
    step(1);
    touch_food = 1'b0;
    step(3);
    check("t5_delay_hold0", {f2x, f2y}, 8'hA7);
    tick = 1'b1; step(1); tick = 1'b0;
    step(3);
    check("t5_delay_hold1", {f2x, f2y}, 8'hA7);
    check("t5_delay_busy", busy2, 1);
    tick = 1'b1; step(1); tick = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      if (done2) got = 1;
      else step(1);
    end
    check("t5_delay_done", got, 1);
    check("t5_delay_moved", ({f2x, f2y} != 8'hA7), 1);
    step(4);

    // reset in the middle of a respawn
    touch_food = 1'b1;
    step(1);
    touch_food = 1'b0;
    step(1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy0", busy0, 0);
    check("mid_rst_food0", {f0x, f0y}, 8'hA7);
    check("mid_rst_poison0", {p0x, p0y}, 8'h53);
    step(1);
    rst_n = 1'b1;
    step(1);

`ifdef POISON_TIMEOUT_EN
    // 6: poison timeout fires once per 40 ticks
    for (int r = 0; r < 2; r++) begin
      p_old = {p0x, p0y};
      repeat (39) begin
        tick = 1'b1; step(1); tick = 1'b0; step(1);
      end
      check("t6_no_early", {p0x, p0y}, p_old);
      check("t6_idle_busy", busy0, 0);
      tick = 1'b1; step(1); tick = 1'b0;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        step(1);
        if (done0) got = 1;
      end
      check("t6_timeout_done", got, 1);
      check("t6_poison_moved", ({p0x, p0y} != p_old), 1);
      step(2);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
